// File: rtl/lfsr_checker.sv
// Receive-side checker for a 4-bit Fibonacci LFSR stream: self-synchronising
// predictor with lock/unlock hysteresis and saturating error/word counters.
module lfsr_checker #(
  parameter int LOCK_LEN   = 4,
  parameter int UNLOCK_LEN = 3,
  parameter int ERR_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       in_word,
  input  logic             clear,
  output logic             locked,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic             zero_seen
);

  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    LOCKED = 2'b01
  } state_t;

  localparam int RUN_W  = $clog2(LOCK_LEN + 1);
  localparam int MISS_W = $clog2(UNLOCK_LEN + 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_LEN - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_LEN - 1);

  state_t            cur;
  logic [3:0]        prev;
  logic              has_prev;
  logic [RUN_W-1:0]  run;
  logic [MISS_W-1:0] miss;
  logic [3:0]        expected;
  logic              match;

  // All-zero is the LFSR lock-up state; it predicts itself, so it never matches.
  assign expected = {prev[0] ^ prev[1], prev[3:1]};
  assign match    = (in_word == expected) && (in_word != 4'd0);
  assign state    = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= SEARCH;
      prev       <= 4'd0;
      has_prev   <= 1'b0;
      run        <= '0;
      miss       <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
      zero_seen  <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        if (in_word == 4'd0) zero_seen <= 1'b1;
        case (cur)
          SEARCH: begin
            prev <= in_word;
            if (!has_prev) begin
              has_prev <= 1'b1;
              run      <= '0;
            end else if (match) begin
              if (run == RUN_LAST) begin
                cur    <= LOCKED;
                locked <= 1'b1;
                run    <= '0;
                miss   <= '0;
              end else begin
                run <= run + RUN_W'(1);
              end
            end else begin
              run <= '0;
            end
          end
          LOCKED: begin
            if (!(&word_count)) word_count <= word_count + CNT_W'(1);
            if (match) begin
              prev <= in_word;
              miss <= '0;
            end else begin
              // Flywheel on the prediction so one corrupted word costs one error.
              prev      <= expected;
              err_pulse <= 1'b1;
              if (!(&err_count)) err_count <= err_count + ERR_W'(1);
              if (miss == MISS_LAST) begin
                cur      <= SEARCH;
                locked   <= 1'b0;
                has_prev <= 1'b0;
                miss     <= '0;
              end else begin
                miss <= miss + MISS_W'(1);
              end
            end
          end
          default: begin
            cur    <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
      if (clear) begin
        err_count  <= '0;
        word_count <= '0;
        zero_seen  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a default instance and a narrow-counter
// instance (ERR_W=2, CNT_W=4) share stimulus; a monitor pops expectations.
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inValid;
  logic [3:0] inWord;
  logic       clear;

  logic        lockedA, pulseA, zeroA;
  logic [1:0]  stateA;
  logic [7:0]  errA;
  logic [15:0] wcA;
  logic        lockedB, pulseB, zeroB;
  logic [1:0]  stateB;
  logic [1:0]  errB;
  logic [3:0]  wcB;

  typedef struct {
    logic  lock;
    logic  pulse;
    int    err;
    int    wc;
    logic  zero;
    string tag;
  } exp_t;

  exp_t  scoreQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;
  bit    vldD = 1'b0;
  string phase = "init";
  int    stepNo = 0;

  always #5 clk = ~clk;

  lfsr_checker dutA (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_word(inWord), .clear(clear),
    .locked(lockedA), .state(stateA), .err_pulse(pulseA), .err_count(errA),
    .word_count(wcA), .zero_seen(zeroA)
  );

  lfsr_checker #(.ERR_W(2), .CNT_W(4)) dutB (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_word(inWord), .clear(clear),
    .locked(lockedB), .state(stateB), .err_pulse(pulseB), .err_count(errB),
    .word_count(wcB), .zero_seen(zeroB)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] w, input logic clr, input logic eLock,
                               input logic ePulse, input int eErr, input int eWc, input logic eZero);
    exp_t e;
    e.lock = eLock; e.pulse = ePulse; e.err = eErr; e.wc = eWc; e.zero = eZero;
    e.tag = $sformatf("%s#%0d w=%0h", phase, stepNo, w);
    stepNo++;
    scoreQ.push_back(e);
    inValid = 1'b1;
    inWord  = w;
    clear   = clr;
    @(negedge clk);
    inValid = 1'b0;
    clear   = 1'b0;
  endtask

  task automatic idle(input int n);
    inValid = 1'b0;
    clear   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " lockedA"}, lockedA, 0);
    checkOutput({tag, " stateA"}, stateA, 0);
    checkOutput({tag, " pulseA"}, pulseA, 0);
    checkOutput({tag, " errA"}, errA, 0);
    checkOutput({tag, " wcA"}, wcA, 0);
    checkOutput({tag, " zeroA"}, zeroA, 0);
    checkOutput({tag, " lockedB"}, lockedB, 0);
    checkOutput({tag, " errB"}, errB, 0);
    checkOutput({tag, " wcB"}, wcB, 0);
  endtask

  // Marks cycles whose outputs reflect a valid input word
  always @(posedge clk) vldD <= inValid && rst_n;

  // Monitor: one expectation per accepted word; idle cycles must not pulse
  always @(negedge clk) begin
    if (vldD) begin
      if (scoreQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL scoreboard underflow: got output with no expectation, expected none");
      end else begin
        exp_t e;
        int   eErrB, eWcB;
        e = scoreQ.pop_front();
        eErrB = (e.err > 3) ? 3 : e.err;
        eWcB  = (e.wc > 15) ? 15 : e.wc;
        checkOutput({e.tag, " lockedA"}, lockedA, e.lock);
        checkOutput({e.tag, " stateA"}, stateA, e.lock ? 2'b01 : 2'b00);
        checkOutput({e.tag, " pulseA"}, pulseA, e.pulse);
        checkOutput({e.tag, " errA"}, errA, e.err);
        checkOutput({e.tag, " wcA"}, wcA, e.wc);
        checkOutput({e.tag, " zeroA"}, zeroA, e.zero);
        checkOutput({e.tag, " lockedB"}, lockedB, e.lock);
        checkOutput({e.tag, " pulseB"}, pulseB, e.pulse);
        checkOutput({e.tag, " errB"}, errB, eErrB);
        checkOutput({e.tag, " wcB"}, wcB, eWcB);
        checkOutput({e.tag, " zeroB"}, zeroB, e.zero);
      end
    end else begin
      checkOutput("idle pulseA", pulseA, 0);
      checkOutput("idle pulseB", pulseB, 0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] period [15];
    logic [3:0] singles [10];
    int         errNow;
    period  = '{4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB};
    singles = '{4'h1, 4'hA, 4'h2, 4'hE, 4'h4, 4'h7, 4'h6, 4'h1, 4'h9, 4'h4};

    rst_n = 1'b0; inValid = 1'b0; inWord = 4'h0; clear = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    idle(1);

    phase = "lock";
    applyStimulus(4'h9, 0, 0, 0, 0, 0, 0);
    applyStimulus(4'hC, 0, 0, 0, 0, 0, 0);
    applyStimulus(4'h6, 0, 0, 0, 0, 0, 0);
    applyStimulus(4'hB, 0, 0, 0, 0, 0, 0);
    applyStimulus(4'h5, 0, 1, 0, 0, 0, 0);

    phase = "zeroword";
    applyStimulus(4'hA, 0, 1, 0, 0, 1, 0);
    applyStimulus(4'h0, 0, 1, 1, 1, 2, 1);
    applyStimulus(4'hE, 0, 1, 0, 1, 3, 1);
    applyStimulus(4'hF, 0, 1, 0, 1, 4, 1);

    phase = "unlock";
    applyStimulus(4'h5, 0, 1, 1, 2, 5, 1);
    applyStimulus(4'h5, 0, 1, 1, 3, 6, 1);
    applyStimulus(4'h5, 0, 0, 1, 4, 7, 1);
    applyStimulus(4'h2, 0, 0, 0, 4, 7, 1);
    applyStimulus(4'h9, 0, 0, 0, 4, 7, 1);
    applyStimulus(4'hC, 0, 0, 0, 4, 7, 1);
    applyStimulus(4'h6, 0, 0, 0, 4, 7, 1);
    applyStimulus(4'hB, 0, 1, 0, 4, 7, 1);

    phase = "gaps";
    for (int i = 0; i < 15; i++) begin
      applyStimulus(period[i], 0, 1, 0, 4, 8 + i, 1);
      idle($urandom_range(0, 2));
    end

    phase = "singles";
    errNow = 4;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) errNow++;
      applyStimulus(singles[i], 0, 1, (i % 2 == 0), errNow, 23 + i, 1);
    end

    phase = "clear";
    applyStimulus(4'h5, 1, 1, 1, 0, 0, 0);
    applyStimulus(4'h9, 0, 1, 0, 0, 1, 0);

    phase = "asyncrst";
    #2 rst_n = 1'b0;
    #1 checkAllZero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    applyStimulus(4'h9, 0, 0, 0, 0, 0, 0);
    applyStimulus(4'hC, 0, 0, 0, 0, 0, 0);
    applyStimulus(4'h6, 0, 0, 0, 0, 0, 0);
    applyStimulus(4'hB, 0, 0, 0, 0, 0, 0);
    applyStimulus(4'h5, 0, 1, 0, 0, 0, 0);

    phase = "zeros";
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 20; i++) applyStimulus(4'h0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 10 && scoreQ.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard drained", scoreQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
